// File: rtl/cmp_pkg.sv
// cmp_pkg: relation-state encoding and helpers shared by the comparator tracker.
// Encoding is numeric so that BELOW < EQUAL < ABOVE holds as plain unsigned order.
package cmp_pkg;

    typedef logic [1:0] cmp_state_t;

    localparam cmp_state_t ST_UNKNOWN = 2'b00;
    localparam cmp_state_t ST_BELOW   = 2'b01;
    localparam cmp_state_t ST_EQUAL   = 2'b10;
    localparam cmp_state_t ST_ABOVE   = 2'b11;

    function automatic logic rank_higher(
        input cmp_state_t nxt,
        input cmp_state_t cur
    );
        return nxt > cur;
    endfunction

    // Anything other than exactly one flag maps to UNKNOWN (illegal sample).
    function automatic cmp_state_t flag_class(
        input logic gt,
        input logic eq,
        input logic lt
    );
        case ({gt, eq, lt})
            3'b100:  return ST_ABOVE;
            3'b010:  return ST_EQUAL;
            3'b001:  return ST_BELOW;
            default: return ST_UNKNOWN;
        endcase
    endfunction

endpackage

// File: rtl/cmp_debounce.sv
// cmp_debounce: tracks the candidate relation and its run of identical samples,
// raising commit on the edge the run reaches DEBOUNCE against a differing state.
module cmp_debounce
    import cmp_pkg::*;
#(
    parameter int DEBOUNCE = 3
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       in_valid,
    input  logic       a_gt_b,
    input  logic       a_eq_b,
    input  logic       a_lt_b,
    input  cmp_state_t state,
    output logic       commit,
    output cmp_state_t cand,
    output logic       bad
);

    localparam logic [3:0] RUN_MAX = 4'(DEBOUNCE);

    cmp_state_t cls;
    cmp_state_t cand_q;
    cmp_state_t cand_d;
    logic [3:0] run_q;
    logic [3:0] run_d;
    logic       legal;

    always_comb begin
        cls    = flag_class(a_gt_b, a_eq_b, a_lt_b);
        legal  = in_valid && (cls != ST_UNKNOWN);
        bad    = in_valid && (cls == ST_UNKNOWN);
        cand_d = cand_q;
        run_d  = run_q;
        if (bad) begin
            cand_d = ST_UNKNOWN;
            run_d  = 4'd0;
        end else if (legal) begin
            if (cls == cand_q) begin
                if (run_q != RUN_MAX) run_d = run_q + 4'd1;
            end else begin
                cand_d = cls;
                run_d  = 4'd1;
            end
        end
        commit = legal && !clr && (run_d == RUN_MAX) && (cand_d != state);
    end

    assign cand = cand_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q <= ST_UNKNOWN;
            run_q  <= 4'd0;
        end else if (clr) begin
            cand_q <= ST_UNKNOWN;
            run_q  <= 4'd0;
        end else begin
            cand_q <= cand_d;
            run_q  <= run_d;
        end
    end

endmodule

// File: rtl/cmp_state_tracker.sv
// cmp_state_tracker: debounced relation state, crossing pulses/counter, one-hot error.
// Optional CMP_TRACK_DWELL_EN adds dwell_cnt (legal samples since last commit).
module cmp_state_tracker
    import cmp_pkg::*;
#(
    parameter int DEBOUNCE = 3,
    parameter int CNT_W    = 8
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             a_gt_b,
    input  logic             a_eq_b,
    input  logic             a_lt_b,
    output logic [1:0]       state_o,
    output logic             state_valid,
    output logic             cross_up,
    output logic             cross_down,
    output logic [CNT_W-1:0] cross_cnt,
`ifdef CMP_TRACK_DWELL_EN
    output logic [15:0]      dwell_cnt,
`endif
    output logic             err_onehot
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic       commit;
    logic       bad;
    cmp_state_t cand;

    cmp_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_deb (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .in_valid (in_valid),
        .a_gt_b   (a_gt_b),
        .a_eq_b   (a_eq_b),
        .a_lt_b   (a_lt_b),
        .state    (state_o),
        .commit   (commit),
        .cand     (cand),
        .bad      (bad)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_o     <= ST_UNKNOWN;
            state_valid <= 1'b0;
            cross_up    <= 1'b0;
            cross_down  <= 1'b0;
            cross_cnt   <= '0;
            err_onehot  <= 1'b0;
        end else if (clr) begin
            state_o     <= ST_UNKNOWN;
            state_valid <= 1'b0;
            cross_up    <= 1'b0;
            cross_down  <= 1'b0;
            cross_cnt   <= '0;
            err_onehot  <= 1'b0;
        end else begin
            cross_up   <= 1'b0;
            cross_down <= 1'b0;
            if (bad) err_onehot <= 1'b1;
            if (commit) begin
                state_o     <= cand;
                state_valid <= 1'b1;
                // The first commit out of UNKNOWN is not a crossing.
                if (state_o != ST_UNKNOWN) begin
                    cross_up   <= rank_higher(cand, state_o);
                    cross_down <= !rank_higher(cand, state_o);
                    if (cross_cnt != CNT_MAX) cross_cnt <= cross_cnt + CNT_ONE;
                end
            end
        end
    end

`ifdef CMP_TRACK_DWELL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_cnt <= 16'd0;
        end else if (clr || commit) begin
            dwell_cnt <= 16'd0;
        end else if (in_valid && !bad && dwell_cnt != 16'hFFFF) begin
            dwell_cnt <= dwell_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/cmp_state_tracker.md
Name: cmp_state_tracker

Overview:
- Downstream consumer of the 4-bit magnitude comparator's one-hot flags (a_gt_b, a_eq_b, a_lt_b).
- Debounces the per-sample relation over DEBOUNCE consecutive valid samples and holds a committed relation state.
- Emits single-cycle crossing pulses, a saturating crossing counter and a sticky one-hot-violation error.
- Feeds threshold/alarm logic that must not react to single-sample glitches.

Parameters:
DEBOUNCE, 3, consecutive identical valid samples required to commit a new state; legal 1..15
CNT_W, 8, width of crossing counter

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous clear to reset values
in_valid  input  1  comparator flags valid this cycle
a_gt_b  input  1  comparator: a > b
a_eq_b  input  1  comparator: a == b
a_lt_b  input  1  comparator: a < b
state_o  output  2  committed state: 00 UNKNOWN, 01 BELOW, 10 EQUAL, 11 ABOVE
state_valid  output  1  high when state_o != UNKNOWN
cross_up  output  1  one-cycle pulse on committed move to higher rank
cross_down  output  1  one-cycle pulse on committed move to lower rank
cross_cnt  output  CNT_W  count of committed crossings, saturating
err_onehot  output  1  sticky: flags not exactly one-hot while in_valid

Behaviour:
- Reset: one clock; rst_n asynchronous active-low. While rst_n low: state_o=00, state_valid=0, cross_up=0, cross_down=0, cross_cnt=0, err_onehot=0; internal candidate=UNKNOWN, run=0. Reset mid-run discards partial debounce.
- Class mapping: lt→BELOW, eq→EQUAL, gt→ABOVE. Rank order BELOW<EQUAL<ABOVE.
- Legal sample: in_valid=1 and exactly one flag high.
  - If class==candidate: run=min(run+1, DEBOUNCE).
  - Else: candidate=class, run=1.
- Illegal sample (in_valid=1, zero or ≥2 flags high): sample ignored, run=0, candidate=UNKNOWN, err_onehot←1 (sticky until reset/clr).
- in_valid=0: no change to candidate/run; pulses deassert.
- Commit: on the edge where the updated run reaches DEBOUNCE and candidate != state_o, state_o←candidate at that same edge. Latency is 0 cycles after the DEBOUNCE-th sample is registered. DEBOUNCE=1 commits on every differing legal sample.
- Pulses (registered, high exactly one cycle after the commit edge):
  - From UNKNOWN: no pulse, no count.
  - Otherwise cross_up if new rank > old rank, else cross_down.
- cross_cnt: +1 per pulse; saturates at 2^CNT_W−1, no wrap.
- Run at DEBOUNCE with candidate==state_o: holds, no further commits.
- clr=1: synchronous, same values as reset. clr wins over in_valid in the same cycle; that sample is dropped.
- All outputs registered; no combinational input-to-output path.

Optional Feature:
CMP_TRACK_DWELL_EN
- Defined:
  - Adds output dwell_cnt [15:0]: legal valid samples since the last commit.
  - Resets to 0 on commit, reset and clr.
  - Saturates at 16'hFFFF.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package cmp_pkg: state encoding constants (ST_UNKNOWN, ST_BELOW, ST_EQUAL, ST_ABOVE), 2-bit state typedef, rank-compare function.
- Sub-module cmp_debounce: candidate/run counter; outputs commit strobe and candidate.
- Top-level cmp_state_tracker owns committed state, pulses, counters, err.

Test Plan:
- Reset then 3 valid lt samples (DEBOUNCE=3) → state_o=01 after 3rd edge, state_valid=1, no pulse, cross_cnt=0.
- From BELOW, sequence gt,gt,eq,gt,gt,gt → commit ABOVE only after final gt; one cross_up pulse; cross_cnt=1.
- From ABOVE, 3 eq samples with in_valid gaps of 2 idle cycles between → commit EQUAL, cross_down one cycle, cross_cnt=2.
- Illegal flags gt=1,lt=1 with in_valid mid-run → err_onehot=1 stays high, run restarts; 2 further lt samples do not commit, 3rd does.
- CNT_W=2, drive 5 alternating committed crossings → cross_cnt sticks at 3.
- clr asserted same cycle as committing sample → all outputs 0, no pulse; rst_n dropped asynchronously mid-cycle → outputs 0 immediately.
